// File: rtl/comb_seq_pkg.sv
// Shared types and constants for the factorial / permutation / power engine.
// The mode encodings match the calculator's operation-select field.
package comb_seq_pkg;

    localparam logic [1:0] MODE_FACT = 2'd0;
    localparam logic [1:0] MODE_PERM = 2'd1;
    localparam logic [1:0] MODE_POW  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest positive value of a signed w-bit result.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/ovf_mult.sv
// Combinational unsigned multiply that flags any product which would not fit
// a signed WIDTH-bit result. Other calculator engines use it as well.
module ovf_mult
    import comb_seq_pkg::*;
#(
    parameter int WIDTH = 28
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p,
    output logic             ovf
);

    localparam logic [2*WIDTH-1:0] LIMIT = (2*WIDTH)'(sat_max(WIDTH));

    logic [2*WIDTH-1:0] full;

    always_comb begin
        full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        p    = full[WIDTH-1:0];
        ovf  = full > LIMIT;
    end

endmodule

// File: rtl/comb_seq_unit.sv
// Sequential n!, P(n,k) and n^k engine: one multiply per clock, saturating
// on overflow, with operand errors reported alongside the result.
//
// state | meaning
// IDLE  | ready for a request; operands latched on valid_in
// CALC  | one multiply per clock until the counter expires or overflow
// DONE  | valid_out pulse cycle, then back to IDLE
module comb_seq_unit
    import comb_seq_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int CNT_W = WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] n,
    input  logic signed [WIDTH-1:0] k,
    input  logic [1:0]              mode,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic                    ovrflow,
    output logic                    err,
    output logic signed [WIDTH-1:0] d_out
);

    localparam logic [WIDTH-1:0] SAT = WIDTH'(sat_max(WIDTH));

    state_t           state;
    logic [1:0]       op_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mult;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic [WIDTH-1:0] prod;
    logic             prod_ovf;

    logic             in_err;
    logic             pow_short;
    logic [CNT_W-1:0] init_cnt;
    logic [WIDTH-1:0] init_acc;

    ovf_mult #(.WIDTH(WIDTH)) u_mult (
        .a   (acc),
        .b   (mult),
        .p   (prod),
        .ovf (prod_ovf)
    );

    assign ready_in = (state == IDLE);

    // Request decode; only consumed on the accept edge.
    always_comb begin
        in_err = (n < 0)
              || (mode == MODE_RSVD)
              || (((mode == MODE_PERM) || (mode == MODE_POW)) && (k < 0))
              || ((mode == MODE_PERM) && (k > n));
        // 0^k and 1^k need no multiplies; the base itself is the answer.
        pow_short = (mode == MODE_POW) && ((n == 0) || (n == 1)) && (k > 0);
        init_cnt  = '0;
        case (mode)
            MODE_FACT: if (n > 1) init_cnt = CNT_W'(n - 1);
            MODE_PERM: init_cnt = CNT_W'(k);
            MODE_POW:  init_cnt = CNT_W'(k);
            default:   init_cnt = '0;
        endcase
        if (in_err || pow_short) init_cnt = '0;
        init_acc = pow_short ? $unsigned(n) : WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_mode   <= MODE_FACT;
            acc       <= '0;
            mult      <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            valid_out <= 1'b0;
            ovrflow   <= 1'b0;
            err       <= 1'b0;
            d_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        op_mode <= mode;
                        mult    <= $unsigned(n);
                        acc     <= init_acc;
                        cnt     <= init_cnt;
                        err_q   <= in_err;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        d_out     <= err_q ? '0 : $signed(acc);
                        err       <= err_q;
                        ovrflow   <= 1'b0;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else if (prod_ovf) begin
                        // Early exit keeps latency bounded for large n.
                        d_out     <= $signed(SAT);
                        ovrflow   <= 1'b1;
                        err       <= 1'b0;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc <= prod;
                        cnt <= cnt - 1'b1;
                        if (op_mode != MODE_POW) mult <= mult - 1'b1;
                    end
                end
                DONE: begin
                    valid_out <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/comb_seq_unit.md
Name: comb_seq_unit

Overview:
- Parametrised successor of the single-mode factorial engine in the calculator datapath.
- Computes n!, falling factorial P(n,k) = n!/(n-k)!, or integer power n^k.
- Uses one multiply per clock, with a valid/ready handshake, saturating overflow detection and an input-error flag.
- Sits between the calculator operand registers and the result mux.

Parameters:
- WIDTH, 28, signed width of n, k and d_out.
- CNT_W, WIDTH, width of the internal iteration counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- n  in  WIDTH  signed base operand.
- k  in  WIDTH  signed second operand; ignored in factorial mode.
- mode  in  2  operation select: 0 = FACT, 1 = PERM, 2 = POW, 3 = reserved.
- valid_in  in  1  request strobe.
- ready_in  out  1  high only in IDLE; a request is accepted on an edge where valid_in && ready_in.
- valid_out  out  1  one-cycle pulse marking new d_out, ovrflow and err.
- ovrflow  out  1  result exceeded 2^(WIDTH-1)-1.
- err  out  1  illegal operands.
- d_out  out  WIDTH  signed result, held until the next result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - ready_in=1 (combinational from state).
  - valid_out=0, ovrflow=0, err=0, d_out=0, acc=0, cnt=0.
  - Reset mid-computation aborts it; no valid_out is produced.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- Accept edge t0 (IDLE, valid_in=1):
  - Latch mode, n and k into op registers.
  - acc<=1; state<=CALC.
  - cnt<=I, where:
    - FACT: I = (n>1) ? n-1 : 0.
    - PERM: I = k.
    - POW: I = k.
  - Multiplier sequence:
    - FACT: n, n-1, ..., 2.
    - PERM: n, n-1, ..., n-k+1.
    - POW: n repeated.
- Error check at accept. Any of the following sets an internal err_q and forces cnt<=0:
  - n<0;
  - k<0 in PERM or POW;
  - k>n in PERM;
  - mode=3.
- POW shortcut: n in {0,1} with k>0 forces cnt<=0 and preloads acc<=n. 0^0 = 1.
- CALC edge, cnt==0:
  - d_out<=err_q ? 0 : acc.
  - err<=err_q; ovrflow<=0; valid_out<=1; state<=DONE.
- CALC edge, cnt!=0:
  - Form the 2*WIDTH product p = acc*mult.
  - If p > 2^(WIDTH-1)-1:
    - d_out<=2^(WIDTH-1)-1 (saturate); ovrflow<=1; err<=0; valid_out<=1; state<=DONE.
    - The early exit bounds latency for large n.
  - Otherwise acc<=p[WIDTH-1:0]; cnt<=cnt-1; mult steps per mode.
- DONE edge: valid_out<=0; state<=IDLE.
- Latency:
  - valid_out is high in the cycle after edge t0+I+1 (overflow path: earlier).
  - Next accept earliest at edge t0+I+2.
- valid_in while busy (CALC/DONE): ignored. Operand changes while busy: no effect.
- valid_in held high: re-accepted at every edge where ready_in=1, so each IDLE cycle with valid_in starts a new computation.
- All arithmetic is non-negative after the error check. Sign-extension checks are unnecessary, but d_out stays declared signed.

Decomposition:
- Package comb_seq_pkg:
  - Mode constants MODE_FACT/MODE_PERM/MODE_POW/MODE_RSVD.
  - State enum IDLE/CALC/DONE.
  - Function sat_max(WIDTH).
- One natural sub-module, ovf_mult:
  - Combinational WIDTH x WIDTH unsigned multiply.
  - Returns the WIDTH-bit product and an ovf flag (product > 2^(WIDTH-1)-1).
  - Reused by other calculator engines.

Test Plan (WIDTH=28):
- Reset: rst=1 for 5 cycles mid-computation of 8! -> outputs 0, ready_in=1, no valid_out. After release, FACT n=5 pulsed at t0 -> d_out=120, valid_out one cycle after edge t0+5, err=0, ovrflow=0.
- FACT n=8 -> 40320. FACT n=0 and n=1 -> 1, valid_out after edge t0+1. FACT n=11 -> 39916800, no overflow.
- FACT n=12 and n=45 -> ovrflow=1, d_out=134217727, valid_out no later than 13 cycles after accept.
- FACT n=-2 -> err=1, d_out=0. PERM n=3 k=5 -> err=1. mode=3 -> err=1. All after edge t0+1.
- PERM n=10 k=3 -> 720. PERM n=7 k=0 -> 1. POW n=3 k=5 -> 243. POW n=1 k=100000 -> 1 in 2 cycles. POW n=0 k=0 -> 1. POW n=2 k=27 -> ovrflow=1.
- Hold valid_in=1 for 3 cycles with FACT n=5 -> exactly one valid_out. Change n during CALC -> result unchanged (120).
